// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending core stores draining to data memory,
// with word-address forwarding of the youngest matching entry to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [AW-1:0]            DataAdr,
  input  logic [DW-1:0]            WriteData,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     MemReq,
  output logic [AW-1:0]            MemAdr,
  output logic [DW-1:0]            MemWData,
  input  logic                     MemAck,
  input  logic [AW-1:0]            LdAdr,
  output logic                     FwdHit,
  output logic [DW-1:0]            FwdData,
  output logic                     Overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          push, pop;

  logic [AW-1:0] adr_mem [DEPTH];
  logic [DW-1:0] dat_mem [DEPTH];

  // Word match ignores the byte offset; XOR form keeps every address bit in use.
  function automatic logic word_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return ((a ^ b) >> 2) == '0;
  endfunction

  assign Full     = (count_q == CW'(DEPTH));
  assign Empty    = (count_q == '0);
  assign Count    = count_q;
  assign Overflow = overflow_q;
  assign push     = MemWrite && !Full;
  assign pop      = !Empty && MemAck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (MemWrite && Full) overflow_q <= 1'b1;
    end
  end

  // Entry storage is data only; validity is carried entirely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[tail] <= DataAdr;
      dat_mem[tail] <= WriteData;
    end
  end

  assign MemReq   = !Empty;
  assign MemAdr   = Empty ? '0 : adr_mem[head];
  assign MemWData = Empty ? '0 : dat_mem[head];

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    FwdHit  = 1'b0;
    FwdData = '0;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count_q) && word_match(LdAdr, adr_mem[idx])) begin
        FwdHit  = 1'b1;
        FwdData = dat_mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic          Full, Empty;
  logic [2:0]    Count;
  logic          MemReq;
  logic [AW-1:0] MemAdr;
  logic [DW-1:0] MemWData;
  logic          MemAck;
  logic [AW-1:0] LdAdr;
  logic          FwdHit;
  logic [DW-1:0] FwdData;
  logic          Overflow;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .Full(Full), .Empty(Empty), .Count(Count),
    .MemReq(MemReq), .MemAdr(MemAdr), .MemWData(MemWData), .MemAck(MemAck),
    .LdAdr(LdAdr), .FwdHit(FwdHit), .FwdData(FwdData), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of stores in program order.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_ovf <= 1'b0;
    end else begin
      automatic bit was_full = (q.size() == DEPTH);
      automatic bit do_pop   = (q.size() != 0) && MemAck;
      automatic ent_t e;
      if (MemWrite && was_full) m_ovf <= 1'b1;
      if (do_pop) void'(q.pop_front());
      if (MemWrite && !was_full) begin
        e.a = DataAdr;
        e.d = WriteData;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    automatic logic          e_hit = 1'b0;
    automatic logic [DW-1:0] e_fwd = '0;
    foreach (q[i]) begin
      if (q[i].a[AW-1:2] == LdAdr[AW-1:2]) begin
        e_hit = 1'b1;
        e_fwd = q[i].d;
      end
    end
    chk("cyc_count",    64'(Count),    64'(q.size()));
    chk("cyc_full",     64'(Full),     64'(q.size() == DEPTH));
    chk("cyc_empty",    64'(Empty),    64'(q.size() == 0));
    chk("cyc_memreq",   64'(MemReq),   64'(q.size() != 0));
    chk("cyc_memadr",   64'(MemAdr),   64'(q.size() != 0 ? q[0].a : '0));
    chk("cyc_memwdata", 64'(MemWData), 64'(q.size() != 0 ? q[0].d : '0));
    chk("cyc_fwdhit",   64'(FwdHit),   64'(e_hit));
    chk("cyc_fwddata",  64'(FwdData),  64'(e_fwd));
    chk("cyc_overflow", 64'(Overflow), 64'(m_ovf));
  end

  task automatic step(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic ack);
    MemWrite  = mw;
    DataAdr   = a;
    WriteData = d;
    MemAck    = ack;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    MemAck    = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_count",  64'(Count),  64'd0);
    chk("rst_memreq", 64'(MemReq), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    MemAck = 1'b0; LdAdr = '0;
    @(posedge clk);
    #1;
    chk("init_empty",    64'(Empty),    64'd1);
    chk("init_full",     64'(Full),     64'd0);
    chk("init_fwddata",  64'(FwdData),  64'd0);
    reset = 1'b0;

    // Idle after reset
    step(0, 0, 0, 0);
    chk("idle_empty",    64'(Empty),    64'd1);
    chk("idle_count",    64'(Count),    64'd0);
    chk("idle_memreq",   64'(MemReq),   64'd0);
    chk("idle_overflow", 64'(Overflow), 64'd0);

    // Single push then drain
    step(1, 100, 7, 0);
    chk("p1_memreq", 64'(MemReq),   64'd1);
    chk("p1_memadr", 64'(MemAdr),   64'd100);
    chk("p1_wdata",  64'(MemWData), 64'd7);
    chk("p1_count",  64'(Count),    64'd1);
    step(0, 0, 0, 1);
    chk("p1_drained", 64'(Empty), 64'd1);

    // Fill past capacity
    for (int i = 0; i < 5; i++) begin
      step(1, 32'(4 * i), 32'(i + 20), 0);
      if (i == 3) chk("fill_full", 64'(Full), 64'd1);
    end
    chk("fill_overflow", 64'(Overflow), 64'd1);
    chk("fill_count",    64'(Count),    64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 64'(MemAdr), 64'(4 * i));
      step(0, 0, 0, 1);
    end
    chk("drain_empty", 64'(Empty), 64'd1);
    chk("ovf_sticky",  64'(Overflow), 64'd1);
    do_reset();
    chk("ovf_cleared", 64'(Overflow), 64'd0);

    // Forwarding of youngest match, byte offset ignored
    LdAdr = 98;
    step(1, 96, 5, 0);
    chk("fwd_first", 64'(FwdData), 64'd5);
    MemWrite = 1'b1; DataAdr = 96; WriteData = 9;
    #1;
    chk("fwd_same_cycle", 64'(FwdData), 64'd5);
    step(1, 96, 9, 0);
    chk("fwd_hit",   64'(FwdHit),  64'd1);
    chk("fwd_young", 64'(FwdData), 64'd9);
    LdAdr = 200;
    MemWrite = 1'b1; DataAdr = 200; WriteData = 3;
    #1;
    chk("fwd_nopush", 64'(FwdHit), 64'd0);
    MemWrite = 1'b0;
    LdAdr = 98;
    step(0, 0, 0, 1);
    chk("fwd_after_pop1", 64'(FwdData), 64'd9);
    step(0, 0, 0, 1);
    chk("fwd_after_pop2", 64'(FwdHit), 64'd0);
    do_reset();

    // Steady state with simultaneous push and pop across the wrap
    step(1, 32'h10, 1, 0);
    step(1, 32'h14, 2, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'(32'h18 + 4 * i), 32'(i + 3), 1);
      chk("pp_count", 64'(Count),    64'd2);
      chk("pp_order", 64'(MemWData), 64'(i + 2));
    end
    for (int i = 0; i < 2; i++) begin
      chk("pp_drain", 64'(MemWData), 64'(i + 4));
      step(0, 0, 0, 1);
    end
    chk("pp_empty", 64'(Empty), 64'd1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1, 32'(32'h40 + 4 * i), 32'(i + 50), 0);
    chk("ar_count_pre", 64'(Count), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("ar_count",  64'(Count),  64'd0);
    chk("ar_memreq", 64'(MemReq), 64'd0);
    chk("ar_memadr", 64'(MemAdr), 64'd0);
    chk("ar_empty",  64'(Empty),  64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("ar_no_stale", 64'(MemReq), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered store entries (power of two, at least 2).
REQ-002 The block SHALL have parameter AW, default 32, giving the address width in bits.
REQ-003 The block SHALL have parameter DW, default 32, giving the data width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port MemWrite, input, 1 bit: the core's store strobe, one store per cycle while high.
REQ-007 The block SHALL have port DataAdr, input, AW bits: the core's store byte address.
REQ-008 The block SHALL have port WriteData, input, DW bits: the core's store data.
REQ-009 The block SHALL have port Full, output, 1 bit: high when no entry is free; the core stalls its memory stage while this is high.
REQ-010 The block SHALL have port Empty, output, 1 bit: high when no entry is held.
REQ-011 The block SHALL have port Count, output, $clog2(DEPTH)+1 bits: the number of valid entries.
REQ-012 The block SHALL have port MemReq, output, 1 bit: drain request to data memory.
REQ-013 The block SHALL have port MemAdr, output, AW bits: the head entry's address.
REQ-014 The block SHALL have port MemWData, output, DW bits: the head entry's data.
REQ-015 The block SHALL have port MemAck, input, 1 bit: data memory accepts the head entry this cycle.
REQ-016 The block SHALL have port LdAdr, input, AW bits: the core's load address, used for forwarding lookup.
REQ-017 The block SHALL have port FwdHit, output, 1 bit: high when a buffered store matches LdAdr.
REQ-018 The block SHALL have port FwdData, output, DW bits: data of the youngest matching entry.
REQ-019 The block SHALL have port Overflow, output, 1 bit: sticky error flag for a store attempted while Full.

Function
REQ-020 The block SHALL operate as a circular FIFO with head and tail pointers and a Count register; the pointers SHALL wrap modulo DEPTH.
REQ-021 The block SHALL accept a push when MemWrite=1 and Full=0, writing {DataAdr, WriteData} at the tail on that clock edge.
REQ-022 The block SHALL pop the head entry when MemReq=1 and MemAck=1 on the same clock edge.
REQ-023 The block SHALL drive MemReq=!Empty; MemAdr and MemWData SHALL be the head entry, are combinational from state, and SHALL remain stable until popped.
REQ-024 On a simultaneous push and pop, the block SHALL leave Count unchanged, advance both pointers, and preserve FIFO order.
REQ-025 The block SHALL derive Full=(Count==DEPTH) and Empty=(Count==0) combinationally from registered Count; a push while Full SHALL be dropped, even if a pop occurs the same cycle.
REQ-026 A dropped push SHALL set Overflow=1, which SHALL hold until reset.
REQ-027 A store is visible to forwarding and to MemReq no earlier than the cycle after its push (latency 1); a push on an empty buffer SHALL raise MemReq on the next cycle.
REQ-028 Forwarding SHALL compare word addresses only (bits AW-1:2 of LdAdr against each valid entry) and be combinational.
REQ-029 When several valid entries match, FwdData SHALL be the youngest (closest to tail); a same-cycle push SHALL NOT forward.
REQ-030 With no match, FwdHit=0 and FwdData=0.
REQ-031 A popped entry SHALL no longer forward from the following cycle.

Reset
REQ-032 While reset=1, the block SHALL immediately (asynchronously) drive head=tail=0, Count=0, Empty=1, Full=0, MemReq=0, FwdHit=0, Overflow=0; MemAdr, MemWData and FwdData SHALL read 0.
REQ-033 The block SHALL discard all held entries on reset mid-operation, and no MemReq SHALL be issued for them afterwards.

Verification
REQ-034 Reset then idle -> Empty=1, Count=0, MemReq=0, Overflow=0.
REQ-035 Push (100, 7) with MemAck=0 -> next cycle MemReq=1, MemAdr=100, MemWData=7, Count=1; then MemAck=1 for one cycle -> Empty=1.
REQ-036 Five consecutive pushes, addresses 0, 4, 8, 12, 16, with MemAck=0 (DEPTH=4) -> Full=1 after the 4th; the 5th is dropped and Overflow=1; drain order is 0, 4, 8, 12.
REQ-037 Push (96, 5) then (96, 9), and a load at LdAdr=98 -> FwdHit=1, FwdData=9; after both entries drain -> FwdHit=0.
REQ-038 At Count=2, push with MemAck=1 for three cycles, crossing pointer wrap -> Count stays 2 and data drains in push order.
REQ-039 With 3 entries held, assert reset between clock edges -> Count=0 and MemReq=0 before the next edge; no stale entry drains after release.
